issue_queue: RTL and testbench
==============================

# issue_queue

In-order dual-issue instruction queue between decode and the `issue` stage. It is the producer end of the `issue_require` / `iq_size` / `iq_pop_number` interface. Decode writes up to two `ISSUE_QUEUE_ELEMENT` entries per cycle. The two oldest entries are presented to issue, which reports back how many it consumed. `flash` empties the queue; `stall` freezes consumption.

## Interface
Parameters:
- `DEPTH`, default 8: number of entries; power of two, ≥4.

Ports:
- `clk` in 1: clock; single clock domain.
- `rst` in 1: reset, synchronous, active-high.
- `flash` in `bool`: pipeline flush; empties the queue.
- `stall` in `bool`: backend stall; pops are ignored.
- `push_number` in 2: count of valid entries on `push_data` (0..2).
- `push_data` in `ISSUE_QUEUE_ELEMENT[1:0]`: new entries; [0] is older.
- `push_ready` out `bool`: at least 2 free slots.
- `issue_require` out `ISSUE_QUEUE_ELEMENT[1:0]`: [0] is the oldest entry, [1] is the next oldest.
- `iq_size` out 2: number of valid `issue_require` slots (0..2).
- `iq_pop_number` in 2: entries consumed this cycle by issue.
- `occupancy` out $clog2(DEPTH)+1: stored entry count.

## Operation
- Storage:
  - `DEPTH`-entry array with `head` and `tail` pointers of width $clog2(DEPTH) that wrap modulo `DEPTH`.
  - A `count` register holds the occupancy.
- Push:
  - When `push_ready` is high, `push_data[0..push_number-1]` are written at `tail`, `tail+1` (with wrap).
  - `tail` advances by the number of entries written.
  - When `push_ready` is low, the push is discarded entirely. No partial writes occur.
- `push_ready = (DEPTH - count) >= 2`. It is a function of state only, with no combinational path from any input.
- Presentation:
  - `issue_require[i]` = entry at `head+i` when `i < iq_size`; otherwise all-zero.
  - `iq_size = min(count, 2)`.
- Pop:
  - `eff_pop = stall ? 0 : min(iq_pop_number, iq_size)`.
  - `iq_pop_number = 3` is clamped to 2.
  - `head` advances by `eff_pop`.
- Next state: `count_next = count + written − eff_pop`. A push and a pop in the same cycle both take effect.
- Priority: `rst` > `flash` > push/pop.
  - On `rst` or `flash`: `head = tail = count = 0`. That cycle's push and pop are ignored.
  - Storage contents are don't-care after `rst`/`flash`.
- Order is strictly preserved. Entries are never reordered or duplicated.

## Timing
- Reset values:
  - `push_ready = 1`
  - `iq_size = 0`
  - `issue_require = '0`
  - `occupancy = 0`
- Push-to-visible latency: 1 cycle without the bypass option; 0 cycles with it (see Configuration).
- A pop takes effect at the next rising edge. The following cycle presents the new head.
- All outputs are combinational from registered state only, except in bypass mode.
- Boundary cases:
  - Full (`count = DEPTH`): `push_ready = 0`.
  - `count = DEPTH−1`: `push_ready = 0`, even for a single-entry push.
  - Empty: `iq_size = 0` and all pops are ignored.
  - Pointer wrap from `DEPTH−1` to 0 is seamless for both the write pair and the read pair.
  - `flash` during `stall`: the queue is still cleared.

## Configuration
- Macro: `ISSUE_QUEUE_BYPASS_EN`.
- Defined: when `count < 2` and `push_ready` is high:
  - Incoming push entries fill the empty `issue_require` slots in the same cycle, after stored entries.
  - `iq_size = min(count + push_number, 2)`.
  - The pop consumes stored entries first, then bypassed entries.
  - Bypassed entries that are popped are not written. `tail` advances only by the entries that remain.
  - With `stall` high, all pushes are stored normally.
- Undefined: outputs depend only on storage, and the push-to-visible latency is 1 cycle.

## Test plan
- Reset, then idle: `iq_size = 0`, `push_ready = 1`, `occupancy = 0`, `issue_require = '0`.
- Push 2 (A, B), then push 1 (C), with no pops:
  - Cycle 2: `issue_require = {B, A}`, `iq_size = 2`.
  - `occupancy = 3`.
  - Pop 1, and the next cycle shows `{C, B}`.
- Fill `DEPTH = 8` to 7 entries: `push_ready = 0`. A push of 2 is discarded and `occupancy` stays 7. Pop 2, and `push_ready` returns to 1.
- Wrap: cycle 20 entries through with mixed push 2 / pop 1,2. The output order matches the push order exactly, with head/tail crossing index 7→0.
- `stall = 1`, `iq_pop_number = 2`, `occupancy = 4`: `occupancy` stays 4. A simultaneous push of 1 makes it 5.
- `flash` with `push_number = 2` and `iq_pop_number = 2`: the next cycle shows `occupancy = 0` and `iq_size = 0`. With `ISSUE_QUEUE_BYPASS_EN` and the queue empty, a push of (X) shows `iq_size = 1`, `issue_require[0] = X` in the same cycle. Popping 1 leaves `occupancy = 0`.

Source files
------------

// File: rtl/issue_queue.sv
// In-order dual-issue instruction queue between decode and issue.
// Optional same-cycle push-to-issue bypass: define ISSUE_QUEUE_BYPASS_EN.
module issue_queue #(
    parameter int DEPTH  = 8,
    parameter int ELEM_W = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flash,
    input  logic                        stall,
    input  logic [1:0]                  push_number,
    input  logic [1:0][ELEM_W-1:0]      push_data,
    output logic                        push_ready,
    output logic [1:0][ELEM_W-1:0]      issue_require,
    output logic [1:0]                  iq_size,
    input  logic [1:0]                  iq_pop_number,
    output logic [$clog2(DEPTH):0]      occupancy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [ELEM_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;

    logic [1:0]        push_n, pop_req, stored_size;
    logic [1:0]        eff_pop, pop_stored, pop_bypass, written;
    logic [AW-1:0]     rd_ptr1, wr_ptr1;
    logic [ELEM_W-1:0] wr_data0, wr_data1;

    assign push_ready  = (count_q <= CW'(DEPTH - 2));
    assign push_n      = (push_number   == 2'd3) ? 2'd2 : push_number;
    assign pop_req     = (iq_pop_number == 2'd3) ? 2'd2 : iq_pop_number;
    assign stored_size = (count_q >= CW'(2)) ? 2'd2 : count_q[1:0];
    assign rd_ptr1     = head_q + AW'(1);
    assign wr_ptr1     = tail_q + AW'(1);
    assign occupancy   = count_q;

    always_comb begin
        iq_size       = stored_size;
        issue_require = '0;
`ifdef ISSUE_QUEUE_BYPASS_EN
        // Incoming entries fill the slots left empty by stored ones.
        if (count_q < CW'(2) && push_ready) begin
            iq_size = ((3'(count_q[1:0]) + 3'(push_n)) >= 3'd2)
                      ? 2'd2 : (count_q[1:0] + push_n);
        end
`endif
        if (iq_size >= 2'd1) begin
            issue_require[0] = (stored_size >= 2'd1) ? mem_q[head_q] : push_data[0];
        end
        if (iq_size == 2'd2) begin
            if (stored_size == 2'd2)      issue_require[1] = mem_q[rd_ptr1];
            else if (stored_size == 2'd1) issue_require[1] = push_data[0];
            else                          issue_require[1] = push_data[1];
        end

        eff_pop    = stall ? 2'd0 : ((pop_req < iq_size) ? pop_req : iq_size);
        pop_stored = (eff_pop < stored_size) ? eff_pop : stored_size;
        // Nonzero only when bypassed entries were consumed; those are never stored.
        pop_bypass = eff_pop - pop_stored;
        written    = push_ready ? (push_n - pop_bypass) : 2'd0;
        wr_data0   = (pop_bypass == 2'd0) ? push_data[0] : push_data[1];
        wr_data1   = push_data[1];

        head_d  = head_q + AW'(pop_stored);
        tail_d  = tail_q + AW'(written);
        count_d = count_q + CW'(written) - CW'(pop_stored);
    end

    always_ff @(posedge clk) begin
        if (rst || flash) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage has no reset; contents are unobservable until rewritten.
    always_ff @(posedge clk) begin
        if (!rst && !flash) begin
            if (written >= 2'd1) mem_q[tail_q]  <= wr_data0;
            if (written == 2'd2) mem_q[wr_ptr1] <= wr_data1;
        end
    end
endmodule

// File: tb/tb_issue_queue.sv
// Directed self-checking bench for issue_queue (DEPTH=8, 16-bit entries).
module tb_issue_queue;
    localparam int DEPTH = 8;
    localparam int W     = 16;

    logic            clk = 1'b0;
    logic            rst, flash, stall;
    logic [1:0]      push_number, iq_pop_number, iq_size;
    logic [1:0][W-1:0] push_data, issue_require;
    logic            push_ready;
    logic [3:0]      occupancy;

    int n_cmp = 0;
    int n_err = 0;

    issue_queue #(.DEPTH(DEPTH), .ELEM_W(W)) dut (
        .clk(clk), .rst(rst), .flash(flash), .stall(stall),
        .push_number(push_number), .push_data(push_data),
        .push_ready(push_ready), .issue_require(issue_require),
        .iq_size(iq_size), .iq_pop_number(iq_pop_number),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic idle();
        rst = 0; flash = 0; stall = 0;
        push_number = 0; push_data = '0; iq_pop_number = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        $display("txn: push_n=%0d pop_n=%0d stall=%0d flash=%0d -> occ=%0d size=%0d",
                 push_number, iq_pop_number, stall, flash, occupancy, iq_size);
        idle();
        #1;
    endtask

    task automatic push(input logic [1:0] n, input logic [W-1:0] d0, input logic [W-1:0] d1);
        push_number = n; push_data[0] = d0; push_data[1] = d1;
    endtask

    task automatic test_reset();
        idle(); rst = 1; step(); step();
        n_cmp++; if (iq_size !== 2'd0) begin n_err++; $display("FAIL reset_size got %0d exp 0", iq_size); end
        n_cmp++; if (push_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %0b exp 1", push_ready); end
        n_cmp++; if (occupancy !== 4'd0) begin n_err++; $display("FAIL reset_occ got %0d exp 0", occupancy); end
        n_cmp++; if (issue_require !== '0) begin n_err++; $display("FAIL reset_req got %h exp 0", issue_require); end
    endtask

    task automatic test_push_pop();
        push(2, 16'h000A, 16'h000B); step();
        push(1, 16'h000C, 16'h0000); step();
        n_cmp++; if (issue_require[0] !== 16'h000A) begin n_err++; $display("FAIL pp_req0 got %h exp 000a", issue_require[0]); end
        n_cmp++; if (issue_require[1] !== 16'h000B) begin n_err++; $display("FAIL pp_req1 got %h exp 000b", issue_require[1]); end
        n_cmp++; if (iq_size !== 2'd2) begin n_err++; $display("FAIL pp_size got %0d exp 2", iq_size); end
        n_cmp++; if (occupancy !== 4'd3) begin n_err++; $display("FAIL pp_occ got %0d exp 3", occupancy); end
        iq_pop_number = 1; step();
        n_cmp++; if (issue_require[0] !== 16'h000B) begin n_err++; $display("FAIL pop1_req0 got %h exp 000b", issue_require[0]); end
        n_cmp++; if (issue_require[1] !== 16'h000C) begin n_err++; $display("FAIL pop1_req1 got %h exp 000c", issue_require[1]); end
        n_cmp++; if (occupancy !== 4'd2) begin n_err++; $display("FAIL pop1_occ got %0d exp 2", occupancy); end
        iq_pop_number = 3; step();
        n_cmp++; if (occupancy !== 4'd0) begin n_err++; $display("FAIL pop3_occ got %0d exp 0", occupancy); end
        n_cmp++; if (iq_size !== 2'd0) begin n_err++; $display("FAIL pop3_size got %0d exp 0", iq_size); end
        iq_pop_number = 2; step();
        n_cmp++; if (occupancy !== 4'd0) begin n_err++; $display("FAIL empty_pop_occ got %0d exp 0", occupancy); end
    endtask

    task automatic test_full();
        push(2, 16'h0010, 16'h0011); step();
        push(2, 16'h0012, 16'h0013); step();
        push(2, 16'h0014, 16'h0015); step();
        n_cmp++; if (push_ready !== 1'b1) begin n_err++; $display("FAIL occ6_ready got %0b exp 1", push_ready); end
        push(1, 16'h0016, 16'h0000); step();
        n_cmp++; if (occupancy !== 4'd7) begin n_err++; $display("FAIL full_occ got %0d exp 7", occupancy); end
        n_cmp++; if (push_ready !== 1'b0) begin n_err++; $display("FAIL occ7_ready got %0b exp 0", push_ready); end
        push(2, 16'h0020, 16'h0021); step();
        n_cmp++; if (occupancy !== 4'd7) begin n_err++; $display("FAIL discard_occ got %0d exp 7", occupancy); end
        n_cmp++; if (issue_require[0] !== 16'h0010) begin n_err++; $display("FAIL full_req0 got %h exp 0010", issue_require[0]); end
        push(1, 16'h0022, 16'h0000); step();
        n_cmp++; if (occupancy !== 4'd7) begin n_err++; $display("FAIL discard1_occ got %0d exp 7", occupancy); end
        iq_pop_number = 2; step();
        n_cmp++; if (occupancy !== 4'd5) begin n_err++; $display("FAIL drain_occ got %0d exp 5", occupancy); end
        n_cmp++; if (push_ready !== 1'b1) begin n_err++; $display("FAIL drain_ready got %0b exp 1", push_ready); end
        n_cmp++; if (issue_require[0] !== 16'h0012) begin n_err++; $display("FAIL drain_req0 got %h exp 0012", issue_require[0]); end
        n_cmp++; if (issue_require[1] !== 16'h0013) begin n_err++; $display("FAIL drain_req1 got %h exp 0013", issue_require[1]); end
    endtask

    task automatic test_flash();
        flash = 1; push(2, 16'h0040, 16'h0041); iq_pop_number = 2; step();
        n_cmp++; if (occupancy !== 4'd0) begin n_err++; $display("FAIL flash_occ got %0d exp 0", occupancy); end
        n_cmp++; if (iq_size !== 2'd0) begin n_err++; $display("FAIL flash_size got %0d exp 0", iq_size); end
    endtask

    task automatic test_stall();
        push(2, 16'h0030, 16'h0031); step();
        push(2, 16'h0032, 16'h0033); step();
        stall = 1; iq_pop_number = 2; step();
        n_cmp++; if (occupancy !== 4'd4) begin n_err++; $display("FAIL stall_occ got %0d exp 4", occupancy); end
        stall = 1; iq_pop_number = 2; push(1, 16'h0034, 16'h0000); step();
        n_cmp++; if (occupancy !== 4'd5) begin n_err++; $display("FAIL stall_push_occ got %0d exp 5", occupancy); end
        n_cmp++; if (issue_require[0] !== 16'h0030) begin n_err++; $display("FAIL stall_req0 got %h exp 0030", issue_require[0]); end
        stall = 1; flash = 1; step();
        n_cmp++; if (occupancy !== 4'd0) begin n_err++; $display("FAIL stall_flash_occ got %0d exp 0", occupancy); end
    endtask

    // Scoreboard queue tracks order while pointers cross 7 -> 0 several times.
    task automatic test_wrap();
        logic [W-1:0] q[$];
        int pushed = 0;
        int cyc = 0;
        while ((pushed < 20 || q.size() != 0) && cyc < 200) begin
            int sz, pn, popn, ep;
            bit rdy;
            sz = (q.size() >= 2) ? 2 : q.size();
            n_cmp++; if (iq_size !== 2'(sz)) begin n_err++; $display("FAIL wrap_size cyc=%0d got %0d exp %0d", cyc, iq_size, sz); end
            n_cmp++; if (occupancy !== 4'(q.size())) begin n_err++; $display("FAIL wrap_occ cyc=%0d got %0d exp %0d", cyc, occupancy, q.size()); end
            if (sz >= 1) begin
                n_cmp++; if (issue_require[0] !== q[0]) begin n_err++; $display("FAIL wrap_req0 cyc=%0d got %h exp %h", cyc, issue_require[0], q[0]); end
            end
            if (sz == 2) begin
                n_cmp++; if (issue_require[1] !== q[1]) begin n_err++; $display("FAIL wrap_req1 cyc=%0d got %h exp %h", cyc, issue_require[1], q[1]); end
            end
            rdy  = (q.size() <= DEPTH - 2);
            pn   = (pushed >= 20) ? 0 : ((20 - pushed >= 2) ? 2 : 1);
            popn = (cyc % 3 == 0) ? 1 : 2;
            if (cyc < 6) popn = 0;
            push(2'(pn), 16'(16'h0100 + pushed), 16'(16'h0101 + pushed));
            iq_pop_number = 2'(popn);
            ep = (popn < sz) ? popn : sz;
            for (int k = 0; k < ep; k++) void'(q.pop_front());
            if (rdy) begin
                for (int k = 0; k < pn; k++) q.push_back(16'(16'h0100 + pushed + k));
                pushed += pn;
            end
            step();
            cyc++;
        end
        n_cmp++; if (cyc >= 200) begin n_err++; $display("FAIL wrap_timeout got %0d exp <200", cyc); end
    endtask

`ifdef ISSUE_QUEUE_BYPASS_EN
    task automatic test_bypass();
        flash = 1; step();
        push(1, 16'h0055, 16'h0000); iq_pop_number = 1; #1;
        n_cmp++; if (iq_size !== 2'd1) begin n_err++; $display("FAIL byp_size got %0d exp 1", iq_size); end
        n_cmp++; if (issue_require[0] !== 16'h0055) begin n_err++; $display("FAIL byp_req0 got %h exp 0055", issue_require[0]); end
        step();
        n_cmp++; if (occupancy !== 4'd0) begin n_err++; $display("FAIL byp_occ got %0d exp 0", occupancy); end
    endtask
`endif

    initial begin
        idle();
        test_reset();
        test_push_pop();
        test_full();
        test_flash();
        test_stall();
        test_wrap();
`ifdef ISSUE_QUEUE_BYPASS_EN
        test_bypass();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
